// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: issues EX/MEM loads/stores to a stallable data memory,
// stalls the upstream pipeline while an access is outstanding and sequences halt/error retirement.
module mem_stage_ctrl #(
    parameter int TIMEOUT     = 16,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        halt_in,
    input  logic        createdump_in,
    input  logic [15:0] addr_in,
    input  logic [15:0] wdata_in,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_done,
    input  logic [15:0] mem_rdata,
    output logic        pipe_stall,
    output logic        wb_valid,
    output logic [15:0] rdata_out,
    output logic        err_out,
    output logic        halt_out,
    output logic        dump_out
);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HALTED} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic          wr_q, wr_d;
    logic          hpend_q, hpend_d;
    logic          dpend_q, dpend_d;
    logic          err_q, err_d;
    logic          halt_q, halt_d;
    logic          dump_q, dump_d;

    logic          en_c, wr_c, stall_c, wbv_c;
    logic [15:0]   addr_c, wdata_c, rdata_c;
    logic          mem_op, is_halt, misalign;

    assign mem_op   = valid_in & (MemRead_in | MemWrite_in);
    assign is_halt  = valid_in & halt_in;
    assign misalign = ALIGN_CHECK & addr_in[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            hpend_q <= 1'b0;
            dpend_q <= 1'b0;
            err_q   <= 1'b0;
            halt_q  <= 1'b0;
            dump_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            hpend_q <= hpend_d;
            dpend_q <= dpend_d;
            err_q   <= err_d;
            halt_q  <= halt_d;
            dump_q  <= dump_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        hpend_d = hpend_q;
        dpend_d = dpend_q;
        err_d   = err_q;
        halt_d  = halt_q;
        dump_d  = 1'b0;
        en_c    = 1'b0;
        wr_c    = 1'b0;
        addr_c  = '0;
        wdata_c = '0;
        stall_c = 1'b0;
        wbv_c   = 1'b0;
        rdata_c = '0;

        case (state_q)
            S_IDLE: begin
                if (mem_op && misalign) begin
                    stall_c = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_HALTED;
                end else if (mem_op) begin
                    en_c    = 1'b1;
                    wr_c    = MemWrite_in;
                    addr_c  = addr_in;
                    wdata_c = wdata_in;
                    if (mem_done) begin
                        wbv_c   = 1'b1;
                        rdata_c = MemWrite_in ? 16'h0000 : mem_rdata;
                        if (is_halt) begin
                            stall_c = 1'b1;
                            halt_d  = 1'b1;
                            dump_d  = createdump_in;
                            state_d = S_HALTED;
                        end
                    end else begin
                        // Latch the request so the memory sees stable values while EX/MEM is frozen.
                        stall_c = 1'b1;
                        addr_d  = addr_in;
                        wdata_d = wdata_in;
                        wr_d    = MemWrite_in;
                        hpend_d = is_halt;
                        dpend_d = is_halt & createdump_in;
                        cnt_d   = '0;
                        state_d = S_WAIT;
                    end
                end else if (is_halt) begin
                    wbv_c   = 1'b1;
                    stall_c = 1'b1;
                    halt_d  = 1'b1;
                    dump_d  = createdump_in;
                    state_d = S_HALTED;
                end else begin
                    wbv_c = valid_in;
                end
            end
            S_WAIT: begin
                en_c    = 1'b1;
                wr_c    = wr_q;
                addr_c  = addr_q;
                wdata_c = wdata_q;
                if (mem_done) begin
                    wbv_c   = 1'b1;
                    rdata_c = wr_q ? 16'h0000 : mem_rdata;
                    if (hpend_q) begin
                        stall_c = 1'b1;
                        halt_d  = 1'b1;
                        dump_d  = dpend_q;
                        state_d = S_HALTED;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    stall_c = 1'b1;
                    if (cnt_q == CW'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = S_HALTED;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_HALTED: begin
                stall_c = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Combinational outputs are held low for as long as reset is asserted.
    assign mem_en     = rst & en_c;
    assign mem_wr     = rst & wr_c;
    assign mem_addr   = rst ? addr_c : 16'h0000;
    assign mem_wdata  = rst ? wdata_c : 16'h0000;
    assign pipe_stall = rst & stall_c;
    assign wb_valid   = rst & wbv_c;
    assign rdata_out  = rst ? rdata_c : 16'h0000;
    assign err_out    = err_q;
    assign halt_out   = halt_q;
    assign dump_out   = dump_q;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: directed scenarios followed by randomized traffic,
// checked against a transaction-level model of the memory stage and a behavioural memory.
module tb_mem_stage_ctrl;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, MemRead_in, MemWrite_in, halt_in, createdump_in;
    logic [15:0] addr_in, wdata_in;
    logic        mem_en, mem_wr, mem_done;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        pipe_stall, wb_valid, err_out, halt_out, dump_out;
    logic [15:0] rdata_out;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.TIMEOUT(TO), .ALIGN_CHECK(1'b1)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .MemRead_in(MemRead_in),
        .MemWrite_in(MemWrite_in), .halt_in(halt_in), .createdump_in(createdump_in),
        .addr_in(addr_in), .wdata_in(wdata_in), .mem_en(mem_en), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_done(mem_done),
        .mem_rdata(mem_rdata), .pipe_stall(pipe_stall), .wb_valid(wb_valid),
        .rdata_out(rdata_out), .err_out(err_out), .halt_out(halt_out), .dump_out(dump_out)
    );

    typedef struct packed {
        logic        en;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        stall;
        logic        wbv;
        logic [15:0] rdata;
        logic        err;
        logic        halt;
        logic        dump;
    } obs_t;

    obs_t        exp_q[$];
    string       tag_q[$];
    logic [15:0] cmp_q[$];
    int          checks = 0;
    int          errors = 0;
    string       cur_tag;

    logic [15:0] mem [logic [15:0]];

    // Model of the stage: one optional outstanding access plus sticky status.
    bit          m_halted, m_pend, m_pwr, m_phalt, m_pdump, m_err, m_hlt, m_dmp;
    logic [15:0] m_paddr, m_pwd;
    int          m_waited;

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 16'h5A3C);
    endfunction

    task automatic model_reset();
        m_halted = 0; m_pend = 0; m_pwr = 0; m_phalt = 0; m_pdump = 0;
        m_err = 0; m_hlt = 0; m_dmp = 0; m_paddr = '0; m_pwd = '0; m_waited = 0;
    endtask

    task automatic retire_halt(inout obs_t e, output bit nd, input bit dump_req);
        e.stall = 1'b1; m_halted = 1; m_hlt = 1; nd = dump_req;
    endtask

    task automatic step(input bit v, input bit rd, input bit wr, input bit h, input bit cd,
                        input logic [15:0] a, input logic [15:0] wd, input bit done);
        obs_t e;
        bit   nd, is_mem;
        @(posedge clk); #1;
        rst = 1'b1; valid_in = v; MemRead_in = rd; MemWrite_in = wr; halt_in = h;
        createdump_in = cd; addr_in = a; wdata_in = wd; mem_done = done;
        mem_rdata = 16'($urandom);
        e = '0; e.err = m_err; e.halt = m_hlt; e.dump = m_dmp; nd = 0;
        is_mem = v && (rd || wr);
        if (m_halted) begin
            e.stall = 1'b1;
        end else if (m_pend) begin
            e.en = 1'b1; e.wr = m_pwr; e.addr = m_paddr; e.wdata = m_pwd;
            if (done) begin
                e.wbv = 1'b1; m_pend = 0;
                if (!m_pwr) begin mem_rdata = mem_rd(m_paddr); e.rdata = mem_rdata; end
                else mem[m_paddr] = m_pwd;
                if (m_phalt) retire_halt(e, nd, m_pdump);
            end else begin
                e.stall = 1'b1; m_waited++;
                if (m_waited == TO) begin m_pend = 0; m_halted = 1; m_err = 1; end
            end
        end else if (is_mem && a[0]) begin
            e.stall = 1'b1; m_halted = 1; m_err = 1;
        end else if (is_mem) begin
            e.en = 1'b1; e.wr = wr; e.addr = a; e.wdata = wd;
            if (done) begin
                e.wbv = 1'b1;
                if (!wr) begin mem_rdata = mem_rd(a); e.rdata = mem_rdata; end
                else mem[a] = wd;
                if (v && h) retire_halt(e, nd, cd);
            end else begin
                e.stall = 1'b1; m_pend = 1; m_pwr = wr; m_paddr = a; m_pwd = wd;
                m_phalt = h; m_pdump = h && cd; m_waited = 0;
            end
        end else if (v && h) begin
            e.wbv = 1'b1; retire_halt(e, nd, cd);
        end else begin
            e.wbv = v;
        end
        m_dmp = nd;
        exp_q.push_back(e); tag_q.push_back(cur_tag);
        if (e.wbv) cmp_q.push_back(e.rdata);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk); #1;
        rst = 1'b0; valid_in = 0; MemRead_in = 0; MemWrite_in = 0; halt_in = 0;
        createdump_in = 0; addr_in = '0; wdata_in = '0; mem_done = 0; mem_rdata = '0;
        #1;
        checks++;
        if (mem_en !== 1'b0 || pipe_stall !== 1'b0 || wb_valid !== 1'b0 || err_out !== 1'b0 ||
            halt_out !== 1'b0 || dump_out !== 1'b0 || mem_addr !== 16'h0) begin
            errors++;
            $display("FAIL %s async: en=%b stall=%b wbv=%b err=%b halt=%b dump=%b addr=%h, required all 0",
                     tag, mem_en, pipe_stall, wb_valid, err_out, halt_out, dump_out, mem_addr);
        end
        model_reset();
        exp_q.push_back('0); tag_q.push_back(tag);
    endtask

    obs_t        mon_a, mon_e;
    string       mon_t;
    logic [15:0] mon_r;

    always @(negedge clk) begin
        mon_a = {mem_en, mem_wr, mem_addr, mem_wdata, pipe_stall, wb_valid, rdata_out,
                 err_out, halt_out, dump_out};
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_t = tag_q.pop_front();
            checks++;
            if (mon_a !== mon_e) begin
                errors++;
                $display("FAIL %s outputs at %0t: got en=%b wr=%b addr=%h wd=%h stall=%b wbv=%b rd=%h err=%b halt=%b dump=%b, required en=%b wr=%b addr=%h wd=%h stall=%b wbv=%b rd=%h err=%b halt=%b dump=%b",
                         mon_t, $time, mon_a.en, mon_a.wr, mon_a.addr, mon_a.wdata, mon_a.stall,
                         mon_a.wbv, mon_a.rdata, mon_a.err, mon_a.halt, mon_a.dump,
                         mon_e.en, mon_e.wr, mon_e.addr, mon_e.wdata, mon_e.stall,
                         mon_e.wbv, mon_e.rdata, mon_e.err, mon_e.halt, mon_e.dump);
            end
        end
        if (wb_valid === 1'b1) begin
            checks++;
            if (cmp_q.size() == 0) begin
                errors++;
                $display("FAIL writeback at %0t: got wb_valid=1 rdata=%h, required no writeback", $time, rdata_out);
            end else begin
                mon_r = cmp_q.pop_front();
                if (rdata_out !== mon_r) begin
                    errors++;
                    $display("FAIL writeback data at %0t: got %h, required %h", $time, rdata_out, mon_r);
                end
            end
        end
    end

    initial begin
        bit          v, rd, wr, h, cd, done, hang;
        logic [15:0] a, wd;
        rst = 1'b0; valid_in = 0; MemRead_in = 0; MemWrite_in = 0; halt_in = 0;
        createdump_in = 0; addr_in = '0; wdata_in = '0; mem_done = 0; mem_rdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset("reset");

        mem[16'h0010] = 16'hBEEF;
        cur_tag = "load_0cyc";  step(1, 1, 0, 0, 0, 16'h0010, 16'h0000, 1);
        cur_tag = "bubble";     step(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0);
        cur_tag = "store_wait"; step(1, 0, 1, 0, 0, 16'h0020, 16'h1234, 0);
        step(1, 1, 0, 0, 0, 16'h0FFE, 16'h9999, 0);
        step(0, 0, 0, 0, 0, 16'h0FF0, 16'h0000, 0);
        step(1, 0, 0, 0, 0, 16'h3332, 16'h4444, 1);
        cur_tag = "nonmem";     step(1, 0, 0, 0, 0, 16'h0022, 16'h0000, 0);
        cur_tag = "stray_done"; step(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1);
        cur_tag = "load_back";  step(1, 1, 1, 0, 0, 16'h0024, 16'hCAFE, 1);
        step(1, 1, 0, 0, 0, 16'h0024, 16'h0000, 1);

        cur_tag = "misalign";   step(1, 1, 0, 0, 0, 16'h0011, 16'h0000, 1);
        repeat (3) step(1, 1, 0, 0, 0, 16'h0040, 16'h0000, 1);
        do_reset("rst_misalign");

        cur_tag = "timeout";    step(1, 1, 0, 0, 0, 16'h0050, 16'h0000, 0);
        repeat (TO) step(1, 1, 0, 0, 0, 16'h0052, 16'h0000, 0);
        repeat (2) step(1, 1, 0, 0, 0, 16'h0052, 16'h0000, 1);
        do_reset("rst_timeout");

        cur_tag = "halt_dump";  step(1, 0, 0, 1, 1, 16'h0000, 16'h0000, 0);
        repeat (3) step(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0);
        do_reset("rst_halt");

        cur_tag = "halt_mem";   step(1, 1, 0, 1, 1, 16'h0060, 16'h0000, 0);
        step(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1);
        repeat (2) step(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0);
        do_reset("rst_halt_mem");

        cur_tag = "rst_wait";   step(1, 1, 0, 0, 0, 16'h0070, 16'h0000, 0);
        step(1, 1, 0, 0, 0, 16'h0070, 16'h0000, 0);
        do_reset("rst_in_wait");
        cur_tag = "after_rst";  step(1, 1, 0, 0, 0, 16'h0070, 16'h0000, 0);
        step(1, 1, 0, 0, 0, 16'h0070, 16'h0000, 1);

        hang = 0;
        cur_tag = "random";
        for (int i = 0; i < 2500; i++) begin
            if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
                do_reset("rand_rst");
                hang = 0;
                continue;
            end
            if (!m_pend && $urandom_range(0, 79) == 0) hang = 1;
            if (!m_pend && !hang && m_halted) hang = 0;
            v  = $urandom_range(0, 9) < 8;
            rd = 0; wr = 0;
            if ($urandom_range(0, 99) < 55) begin
                rd = 1'($urandom); wr = 1'($urandom);
                if (!rd && !wr) rd = 1;
            end
            h  = $urandom_range(0, 59) == 0;
            cd = 1'($urandom);
            a  = 16'($urandom);
            if ($urandom_range(0, 39) != 0) a[0] = 1'b0;
            wd = 16'($urandom);
            done = hang ? 1'b0 : ($urandom_range(0, 2) == 0);
            if (m_halted) hang = 0;
            step(v, rd, wr, h, cd, a, wd, done);
        end

        @(negedge clk); #1;
        checks++;
        if (exp_q.size() != 0 || cmp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d entries left, required 0/0", exp_q.size(), cmp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
